// File: rtl/serial_tx_fifo.sv
// Memory-mapped UART transmitter with a byte FIFO, programmable baud divisor,
// sticky overflow flag and level interrupt.
module serial_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_RESET  = 86,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic        re,
    input  logic [3:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        tx,
    output logic        irq
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t                 state, state_next;
    logic [7:0]             mem [FIFO_DEPTH];
    logic [PtrW-1:0]        head, tail;
    logic [CntW-1:0]        count;
    logic [7:0]             count8;
    logic                   ovf, ie_empty, ie_ovf;
    logic [DIV_WIDTH-1:0]   div_reg, div_cur, baud_cnt;
    logic [7:0]             shift;
    logic [2:0]             bit_idx;
    logic                   wr_data, wr_div, wr_ctrl, rd_status;
    logic                   full, empty, push, pop, overflow, flush, bit_end, busy;
    logic                   unused_din;

    assign wr_data   = sel & we & (addr == 4'h0);
    assign wr_div    = sel & we & (addr == 4'h8);
    assign wr_ctrl   = sel & we & (addr == 4'hC);
    assign rd_status = sel & re & (addr == 4'h4);

    assign full     = (count == CntW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push     = wr_data & ~full;
    assign overflow = wr_data & full;
    assign flush    = wr_ctrl & din[2];
    assign bit_end  = (baud_cnt == div_cur);
    assign busy     = (state != StIdle);
    assign count8   = 8'(count);
    assign unused_din = ^din;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            StIdle: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = StStart;
                end
            end
            StStart: if (bit_end) state_next = StData;
            StData:  if (bit_end && bit_idx == 3'd7) state_next = StStop;
            StStop: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = StStart;
                    end else begin
                        state_next = StIdle;
                    end
                end
            end
            default: state_next = StIdle;
        endcase
    end

    // Divisor is sampled into div_cur only at frame start and bit boundaries.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= StIdle;
            shift    <= 8'h00;
            bit_idx  <= 3'd0;
            baud_cnt <= '0;
            div_cur  <= DIV_WIDTH'(DIV_RESET);
        end else begin
            state <= state_next;
            if (pop) begin
                shift    <= mem[head];
                baud_cnt <= '0;
                div_cur  <= div_reg;
            end else if (state != StIdle) begin
                if (bit_end) begin
                    baud_cnt <= '0;
                    div_cur  <= div_reg;
                    if (state == StStart) bit_idx <= 3'd0;
                    if (state == StData) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt <= baud_cnt + DIV_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) mem[tail] <= din[7:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PtrW'(1);
            if (pop)  head <= head + PtrW'(1);
            count <= count + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf      <= 1'b0;
            ie_empty <= 1'b0;
            ie_ovf   <= 1'b0;
            div_reg  <= DIV_WIDTH'(DIV_RESET);
        end else begin
            // A dropped byte on the same edge as a STATUS read keeps the flag.
            if (overflow)       ovf <= 1'b1;
            else if (rd_status) ovf <= 1'b0;
            if (wr_ctrl) begin
                ie_empty <= din[0];
                ie_ovf   <= din[1];
            end
            if (wr_div) div_reg <= din[DIV_WIDTH-1:0];
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            4'h4:    dout = {16'b0, count8, 4'b0, ovf, busy, full, empty};
            4'h8:    dout[DIV_WIDTH-1:0] = div_reg;
            4'hC:    dout[1:0] = {ie_ovf, ie_empty};
            default: dout = '0;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            StStart: tx = 1'b0;
            StData:  tx = shift[0];
            default: tx = 1'b1;
        endcase
    end

    assign irq = (ie_empty & empty) | (ie_ovf & ovf);

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Scoreboard bench: expected frames and read data are queued by the stimulus,
// a serial-line monitor and a read monitor pop and compare.
module tb_serial_tx_fifo;
    logic        clock, reset, sel, we, re;
    logic [3:0]  addr;
    logic [31:0] din, dout;
    logic        tx, irq;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [3:0] sw;
        logic       contig;
        logic       abort;
    } frame_t;

    frame_t      exp_q[$];
    logic [31:0] rd_q[$];
    logic [3:0]  rd_a[$];
    int          vectors = 0;
    int          fails = 0;
    logic        mon_busy = 1'b0;

    serial_tx_fifo #(.FIFO_DEPTH(4), .DIV_RESET(86), .DIV_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .sel(sel), .we(we), .re(re),
        .addr(addr), .din(din), .dout(dout), .tx(tx), .irq(irq)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Serial monitor: samples each bit mid-period using the expected bit lengths.
    initial begin : ser_mon
        frame_t     e;
        logic [9:0] bits;
        int         p, guard;
        logic       aborted, want_start;
        want_start = 1'b0;
        forever begin
            @(negedge clock);
            if (want_start) begin
                want_start = 1'b0;
                vectors++;
                if (tx !== 1'b0) begin
                    fails++;
                    $display("FAIL gap: tx=%b after stop bit, required 0 (next start)", tx);
                end
            end
            if (reset === 1'b1 && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL frame: unexpected start bit, required idle line");
                    guard = 0;
                    while (tx === 1'b0 && guard < 4000) begin
                        @(negedge clock);
                        guard++;
                    end
                end else begin
                    e = exp_q.pop_front();
                    mon_busy = 1'b1;
                    aborted = 1'b0;
                    bits = '0;
                    for (int i = 0; i < 10; i++) begin
                        p = (i < int'(e.sw)) ? int'(e.p0) : int'(e.p1);
                        for (int c = 0; c < p; c++) begin
                            if (reset !== 1'b1) aborted = 1'b1;
                            if (aborted) break;
                            if (c == p / 2) bits[i] = tx;
                            if (!(i == 9 && c == p - 1)) @(negedge clock);
                        end
                        if (aborted) break;
                    end
                    vectors++;
                    if (aborted !== e.abort) begin
                        fails++;
                        $display("FAIL abort %h: aborted=%b, required %b", e.data, aborted,
                                 e.abort);
                    end else if (!aborted) begin
                        vectors++;
                        if (bits !== {1'b1, e.data, 1'b0}) begin
                            fails++;
                            $display("FAIL frame %h: line bits %b, required %b", e.data, bits,
                                     {1'b1, e.data, 1'b0});
                        end
                    end
                    want_start = e.contig && !aborted;
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin : rd_mon
        logic [31:0] ex;
        logic [3:0]  a;
        forever begin
            @(negedge clock);
            if (sel === 1'b1 && re === 1'b1) begin
                vectors++;
                if (rd_q.size() == 0) begin
                    fails++;
                    $display("FAIL read: unexpected read of addr %h", addr);
                end else begin
                    ex = rd_q.pop_front();
                    a  = rd_a.pop_front();
                    if (dout !== ex) begin
                        fails++;
                        $display("FAIL read addr %h: dout %h, required %h", a, dout, ex);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; din = d;
        @(posedge clock);
        #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] ex);
        rd_q.push_back(ex);
        rd_a.push_back(a);
        sel = 1'b1; re = 1'b1; addr = a;
        @(posedge clock);
        #1;
        sel = 1'b0; re = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        vectors++;
        if (act !== ex) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, ex);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input int p0, input int p1, input int sw,
                                input logic contig, input logic abort);
        frame_t f;
        f.data = d; f.p0 = 8'(p0); f.p1 = 8'(p1); f.sw = 4'(sw);
        f.contig = contig; f.abort = abort;
        exp_q.push_back(f);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || mon_busy) && g < 5000) begin
            cyc(1);
            g++;
        end
        if (g >= 5000) begin
            vectors++;
            fails++;
            $display("FAIL drain: %0d frames still pending, required 0", exp_q.size());
        end
        cyc(3);
    endtask

    initial begin
        sel = 1'b0; we = 1'b0; re = 1'b0; addr = 4'h0; din = '0; reset = 1'b0;
        #23 reset = 1'b1;
        cyc(1);
        chk("tx_reset", 32'(tx), 32'h1);
        chk("irq_reset", 32'(irq), 32'h0);
        rd(4'h4, 32'h1);
        rd(4'h8, 32'd86);
        rd(4'hC, 32'h0);
        rd(4'h0, 32'h0);
        cyc(20);

        // 0xA5 at DIV=3, plus write-to-start latency
        wr(4'h8, 32'd3);
        rd(4'h8, 32'd3);
        expect_frame(8'hA5, 4, 4, 10, 1'b0, 1'b0);
        wr(4'h0, 32'hA5);
        @(negedge clock);
        chk("latency_enq", 32'(tx), 32'h1);
        @(negedge clock);
        chk("latency_pop", 32'(tx), 32'h0);
        @(posedge clock);
        #1;
        rd(4'h4, 32'h5);
        drain();
        rd(4'h4, 32'h1);

        // back-to-back frames
        expect_frame(8'h01, 4, 4, 10, 1'b1, 1'b0);
        expect_frame(8'h02, 4, 4, 10, 1'b0, 1'b0);
        wr(4'h0, 32'h01);
        wr(4'h0, 32'h02);
        drain();

        // DIV change during data bit 2 takes effect from bit 3
        expect_frame(8'h5A, 4, 2, 4, 1'b0, 1'b0);
        wr(4'h0, 32'h5A);
        cyc(14);
        wr(4'h8, 32'd1);
        drain();
        wr(4'h8, 32'd3);

        // overflow with depth 4 at DIV=9
        wr(4'h8, 32'd9);
        wr(4'hC, 32'h2);
        expect_frame(8'h11, 10, 10, 10, 1'b1, 1'b0);
        expect_frame(8'h12, 10, 10, 10, 1'b1, 1'b0);
        expect_frame(8'h13, 10, 10, 10, 1'b1, 1'b0);
        expect_frame(8'h14, 10, 10, 10, 1'b1, 1'b0);
        expect_frame(8'h15, 10, 10, 10, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) wr(4'h0, 32'h10 + 32'(i));
        @(negedge clock);
        chk("irq_ovf_set", 32'(irq), 32'h1);
        @(posedge clock);
        #1;
        rd(4'h4, 32'h40E);
        @(negedge clock);
        chk("irq_ovf_clr", 32'(irq), 32'h0);
        @(posedge clock);
        #1;
        rd(4'h4, 32'h406);
        rd(4'h8, 32'd9);
        wr(4'hC, 32'h0);
        drain();

        // empty interrupt
        wr(4'h8, 32'd3);
        wr(4'hC, 32'h1);
        @(negedge clock);
        chk("irq_empty", 32'(irq), 32'h1);
        @(posedge clock);
        #1;
        expect_frame(8'h3C, 4, 4, 10, 1'b0, 1'b0);
        wr(4'h0, 32'h3C);
        @(negedge clock);
        chk("irq_enq_drop", 32'(irq), 32'h0);
        @(negedge clock);
        chk("irq_pop_rise", 32'(irq), 32'h1);
        @(posedge clock);
        #1;
        rd(4'hC, 32'h1);
        drain();

        // flush keeps the frame in progress, drops the queued bytes
        expect_frame(8'h77, 4, 4, 10, 1'b0, 1'b0);
        wr(4'h0, 32'h77);
        wr(4'h0, 32'h88);
        wr(4'h0, 32'h99);
        wr(4'hC, 32'h5);
        rd(4'h4, 32'h5);
        rd(4'hC, 32'h1);
        drain();

        // asynchronous reset during data bit 3
        expect_frame(8'hC3, 4, 4, 10, 1'b0, 1'b1);
        wr(4'h0, 32'hC3);
        cyc(18);
        addr = 4'h4;
        #2 reset = 1'b0;
        #1;
        chk("tx_async_rst", 32'(tx), 32'h1);
        chk("status_async_rst", dout, 32'h1);
        chk("irq_async_rst", 32'(irq), 32'h0);
        #3 reset = 1'b1;
        cyc(20);
        rd(4'h4, 32'h1);
        rd(4'h8, 32'd86);
        cyc(2);
        chk("frames_left", 32'(exp_q.size()), 32'h0);
        chk("reads_left", 32'(rd_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/serial_tx_fifo.md
SERIAL_TX_FIFO -- requirements
Module: serial_tx_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock port is named clock and the reset port is named reset.
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL set the number of byte entries; it SHALL be a power of two, minimum 2.
REQ-003 Parameter DIV_RESET, default 86, SHALL set the reset value of the baud divisor (10 MHz / 115200).
REQ-004 Parameter DIV_WIDTH, default 16, SHALL set the width of the baud divisor register.
REQ-005 clock  in  1  system clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous active-low reset.
REQ-007 sel  in  1  MMIO window select from address decode.
REQ-008 we  in  1  write strobe; a write occurs only when sel & we.
REQ-009 re  in  1  read strobe; a read side effect occurs only when sel & re.
REQ-010 addr  in  4  byte offset: 0x0 DATA, 0x4 STATUS, 0x8 DIV, 0xC CTRL.
REQ-011 din  in  32  write data.
REQ-012 dout  out  32  read data, combinational from addr.
REQ-013 tx  out  1  serial line output, idle high.
REQ-014 irq  out  1  level interrupt: (CTRL.ie_empty & empty) | (CTRL.ie_ovf & ovf).

Function
REQ-015 A write to DATA SHALL enqueue din[7:0] at the tail on that edge if the FIFO is not full.
REQ-016 A write to DATA while full SHALL drop the byte, leave FIFO contents and count unchanged, and set sticky ovf.
REQ-017 STATUS read value SHALL be {16'b0, count[7:0], 4'b0, ovf, busy, full, empty}, with count in 0..FIFO_DEPTH.
REQ-018 A read of STATUS with sel & re SHALL clear ovf on that edge; an overflow on the same edge SHALL win and leave ovf set.
REQ-019 A write to DIV SHALL load din[DIV_WIDTH-1:0]; the new value SHALL apply from the next bit boundary, never mid-bit.
REQ-020 Bit period SHALL be DIV+1 clock cycles; DIV=0 gives 1 cycle per bit.
REQ-021 CTRL bits SHALL be [0] ie_empty, [1] ie_ovf, [2] flush; flush is self-clearing, empties the FIFO in one cycle, and does not abort the frame in progress.
REQ-022 Reads of DATA SHALL return 0; reads of DIV and CTRL SHALL return their current values, with CTRL[2] reading 0.
REQ-023 The transmitter FSM SHALL have states IDLE, START, DATA, STOP.
REQ-024 IDLE: tx=1; if the FIFO is non-empty, pop the head into the shift register and go to START on the same edge.
REQ-025 START: tx=0 for one bit period, then DATA with bit index 0.
REQ-026 DATA: tx=shift[0], LSB first; shift right at each bit end; after bit 7, go to STOP.
REQ-027 STOP: tx=1 for one bit period; then, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 A simultaneous enqueue and pop SHALL leave count unchanged and keep both bytes in order; enqueue while full is still dropped even if a pop occurs on the same edge.
REQ-030 Head and tail pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be derived from count, not from pointer equality.
REQ-031 The latency from the DATA write edge to the tx falling edge SHALL be 2 cycles when the FSM is IDLE: one cycle to enqueue, then the pop edge.

Reset
REQ-032 On reset assertion, asynchronously: FIFO empty, count=0, ovf=0, CTRL=0, DIV=DIV_RESET, FSM=IDLE, tx=1, irq=0, baud counter=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately, with tx high; the FIFO contents are discarded.
REQ-034 After reset deassertion, no frame SHALL start until a DATA write occurs.

Verification
REQ-035 DIV=3, write 0xA5 -> tx low for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4 cycles; busy falls after STOP.
REQ-036 FIFO_DEPTH=4, DIV=9, write 6 bytes back-to-back while the first is transmitting -> bytes 1-5 are accepted (the first is popped immediately), the 6th is dropped, STATUS shows ovf=1 and full=1, and the next STATUS read returns ovf=0.
REQ-037 Write 0x01 and 0x02 -> the two frames are contiguous: STOP of frame 1 is followed directly by START of frame 2 with zero idle cycles.
REQ-038 CTRL.ie_empty=1 with the FIFO empty -> irq=1; write one byte -> irq drops the next cycle and rises again on the pop edge.
REQ-039 Assert reset during DATA bit 3 -> tx=1, count=0, and STATUS=0x00000001 with no clock edge required.
REQ-040 Write DIV=1 during bit 2 of a frame at DIV=3 -> bit 2 lasts 4 cycles and bit 3 onward lasts 2 cycles.
